priority_encoder_8x3: RTL and testbench
=======================================

// Module: priority_encoder_8x3
// PURPOSE
//  - Inverse of the 3x8 decoder: takes 8 request lines and returns the 3-bit index of the highest pending one.
//  - Sequential version: requests are latched into a pending register.
//  - Codes leave through a valid/ready handshake, one code per accepted transfer.
//  - Sits between peripheral request lines and the datapath control unit, which consumes one code per transfer.
// PARAMETERS
//  - N_IN    8  number of request lines (fixed at 8 for this block)
//  - CODE_W  3  code width, equal to clog2(N_IN)
// PORTS
//  - clk        in   1       rising-edge clock
//  - rst_n      in   1       asynchronous active-low reset
//  - E          in   1       grant enable; low blocks new grants, requests still latched
//  - I          in   8       request pulses/levels, I[7] highest priority
//  - code       out  3       granted index, {A,B,C} with A = MSB
//  - valid      out  1       code holds a granted request
//  - ready      in   1       consumer accepts code at clock edge when valid=1
//  - pending    out  8       latched, not-yet-granted requests
//  - any_pend   out  1       |pending
//  - mask       in   8       only with PENC_MASK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): pending=8'h00, code=3'b000, valid=0, any_pend=0.
//  - Capture: every edge, pending <= (pending & ~grant_onehot) | I.
//    - A request arriving on the same edge its bit is granted stays pending (set wins).
//  - Eligibility: elig = pending (& ~mask when masking is compiled in).
//  - Selection: highest set index of elig; combinational from the pending register.
//  - Grant condition at an edge: E=1 AND elig!=0 AND (valid=0 OR ready=1). On grant:
//    - code <= selected index
//    - valid <= 1
//    - the selected bit is cleared from pending
//  - Accept without grant (valid=1, ready=1, no grant condition): valid <= 0; code holds its last value.
//  - Stall (valid=1, ready=0): code and valid hold; pending keeps accumulating.
//  - Back-to-back: accept and next grant happen on the same edge; no bubble cycle.
//  - Latency: I high before edge k -> pending bit set after edge k -> valid with code after edge k+1.
//    - Latency is 2 edges when the output is free and E=1.
//  - E=0: no grants. The current valid/code still completes its handshake normally.
//  - Repeated I on an already-pending bit: no effect; requests do not count up.
//  - State view:
//    - IDLE (valid=0): goes to HOLD on grant.
//    - HOLD (valid=1): accept+grant -> HOLD with new code; accept only -> IDLE; no accept -> HOLD.
//  - Reset mid-transfer: valid drops immediately and pending is discarded; no partial grant survives.
// CONFIGURATION
//  - Macro PENC_MASK_EN.
//  - Defined:
//    - mask[7:0] input exists; mask bit = 1 makes the line ineligible for grant.
//    - A masked line still latches into pending and is granted once unmasked.
//  - Not defined: no mask port; elig = pending.
// TESTING
//  - Reset: rst_n=0 with I=8'hFF -> pending=0, valid=0, code=0. Release -> pending=FF after the next edge.
//  - Single: I=8'b0010_0000 for 1 cycle, ready=1, E=1.
//    - valid after 2 edges, code=3'b101, pending=0.
//    - valid=0 on the following edge.
//  - Priority drain: I=8'b1001_0010 for 1 cycle, ready=1.
//    - codes 7, 4, 1 on consecutive cycles, then valid=0.
//  - Stall: ready=0 while code=7 with pending=8'b0001_0000.
//    - code stays 7 and valid stays 1 for 5 cycles.
//    - ready=1 -> next edge code=4.
//  - Enable / set-wins:
//    - E=0 with I=8'h01 -> no valid, pending=01. E=1 -> code=0.
//    - I[3] re-asserted on the edge bit 3 is granted -> bit 3 pending again, code=3 granted a second time.
//  - Mask (PENC_MASK_EN): mask=8'h80, I=8'h81 -> code=0 first. Then mask=0 -> code=7.

Source files
------------

// File: rtl/priority_encoder_8x3.sv
// Latched 8-line priority encoder; highest pending request leaves on a valid/ready handshake.
// Optional grant mask port when PENC_MASK_EN is defined.
module priority_encoder_8x3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       E,
    input  logic [7:0] I,
`ifdef PENC_MASK_EN
    input  logic [7:0] mask,
`endif
    input  logic       ready,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending,
    output logic       any_pend
);

    localparam int N_IN   = 8;
    localparam int CODE_W = $clog2(N_IN);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_nxt;
    logic [CODE_W-1:0] w_sel;
    logic [N_IN-1:0]   r_pending;
    logic [N_IN-1:0]   w_pending_nxt;
    logic [N_IN-1:0]   w_elig;
    logic [N_IN-1:0]   w_clr;
    logic              w_grant;

`ifdef PENC_MASK_EN
    assign w_elig = r_pending & ~mask;
`else
    assign w_elig = r_pending;
`endif

    // Ascending scan: the last hit is the highest set index.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (w_elig[k]) begin
                w_sel = CODE_W'(k);
            end
        end
    end

    assign w_grant = E && (|w_elig) && ((r_state == IDLE) || ready);
    assign w_clr   = w_grant ? (N_IN'(1) << w_sel) : '0;

    // New requests are OR-ed in after the clear, so a same-edge request wins.
    assign w_pending_nxt = (r_pending & ~w_clr) | I;

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        unique case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = HOLD;
                    w_code_nxt  = w_sel;
                end
            end
            HOLD: begin
                if (w_grant) begin
                    w_code_nxt = w_sel;
                end else if (ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_code    <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_code    <= w_code_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    assign code     = r_code;
    assign valid    = (r_state == HOLD);
    assign pending  = r_pending;
    assign any_pend = |r_pending;

endmodule

// File: tb/tb_priority_encoder_8x3.sv
// Self-checking bench for priority_encoder_8x3: directed steps then random traffic.
// Exercises the mask port only when PENC_MASK_EN is defined.
module tb_priority_encoder_8x3;

    logic       clk;
    logic       rst_n;
    logic       E;
    logic [7:0] I;
    logic       ready;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       any_pend;
`ifdef PENC_MASK_EN
    logic [7:0] mask;
`endif

    int checks;
    int failures;

    logic [7:0] m_pend;
    logic       m_valid;
    logic [2:0] m_code;

    priority_encoder_8x3 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .E        (E),
        .I        (I),
`ifdef PENC_MASK_EN
        .mask     (mask),
`endif
        .ready    (ready),
        .code     (code),
        .valid    (valid),
        .pending  (pending),
        .any_pend (any_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] cur_mask();
`ifdef PENC_MASK_EN
        return mask;
`else
        return 8'h00;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = 8'h00;
        m_valid = 1'b0;
        m_code  = 3'd0;
    endtask

    // Reference: find the highest eligible line, apply the grant rule,
    // then fold this cycle's requests into the pending set.
    task automatic model_edge();
        logic [7:0] elig;
        int         hi;
        bit         can;
        elig = m_pend & ~cur_mask();
        hi = -1;
        for (int k = 7; k >= 0; k--) begin
            if (elig[k] && hi < 0) hi = k;
        end
        can = E && (hi >= 0) && (!m_valid || ready);
        if (can) begin
            m_code  = 3'(hi);
            m_valid = 1'b1;
            m_pend  = m_pend & ~(8'(1) << hi);
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        m_pend = m_pend | I;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".pending"}, pending, m_pend);
        chk({tag, ".any_pend"}, 8'(any_pend), 8'(m_pend != 0));
        chk({tag, ".valid"}, 8'(valid), 8'(m_valid));
        chk({tag, ".code"}, 8'(code), 8'(m_code));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        E     = 1'b1;
        I     = 8'hFF;
        ready = 1'b1;
`ifdef PENC_MASK_EN
        mask  = 8'h00;
`endif
        model_reset();

        // Reset holds everything clear even with all requests high.
        #1;
        compare_all("rst0");
        @(posedge clk);
        #1;
        compare_all("rst1");
        rst_n = 1'b1;
        tick("rel");
        chk("rel.pend_ff", pending, 8'hFF);
        I = 8'h00;
        for (int n = 0; n < 10; n++) tick("drain_ff");

        // Single request: two-edge latency, then valid drops.
        I = 8'h20;
        tick("single1");
        chk("single1.valid", 8'(valid), 8'h00);
        I = 8'h00;
        tick("single2");
        chk("single2.code", 8'(code), 8'h05);
        chk("single2.valid", 8'(valid), 8'h01);
        tick("single3");
        chk("single3.valid", 8'(valid), 8'h00);

        // Priority drain 7, 4, 1 back to back.
        I = 8'h92;
        tick("prio0");
        I = 8'h00;
        tick("prio7");
        chk("prio7.code", 8'(code), 8'h07);
        tick("prio4");
        chk("prio4.code", 8'(code), 8'h04);
        tick("prio1");
        chk("prio1.code", 8'(code), 8'h01);
        tick("prio_end");
        chk("prio_end.valid", 8'(valid), 8'h00);

        // Stall with code 7 held while bit 4 waits.
        I = 8'h90;
        tick("stall0");
        I = 8'h00;
        ready = 1'b0;
        tick("stall_g");
        chk("stall_g.pend", pending, 8'h10);
        for (int n = 0; n < 5; n++) begin
            tick("stall");
            chk("stall.code", 8'(code), 8'h07);
        end
        ready = 1'b1;
        tick("stall_rel");
        chk("stall_rel.code", 8'(code), 8'h04);
        tick("stall_end");

        // Enable low blocks grants but still latches.
        E = 1'b0;
        I = 8'h01;
        tick("en0");
        I = 8'h00;
        tick("en1");
        chk("en1.valid", 8'(valid), 8'h00);
        chk("en1.pend", pending, 8'h01);
        E = 1'b1;
        tick("en2");
        chk("en2.code", 8'(code), 8'h00);
        chk("en2.valid", 8'(valid), 8'h01);
        tick("en3");

        // Same-edge request on the granted bit stays pending.
        I = 8'h08;
        tick("sw0");
        tick("sw1");
        chk("sw1.pend", pending, 8'h08);
        chk("sw1.code", 8'(code), 8'h03);
        I = 8'h00;
        tick("sw2");
        chk("sw2.code", 8'(code), 8'h03);
        chk("sw2.valid", 8'(valid), 8'h01);
        tick("sw3");

        // Repeated requests while disabled do not count up.
        E = 1'b0;
        I = 8'h04;
        for (int n = 0; n < 3; n++) tick("rep");
        E = 1'b1;
        I = 8'h00;
        tick("rep_g");
        tick("rep_e");
        chk("rep_e.valid", 8'(valid), 8'h00);

`ifdef PENC_MASK_EN
        mask = 8'h80;
        I = 8'h81;
        tick("mask0");
        I = 8'h00;
        tick("mask1");
        chk("mask1.code", 8'(code), 8'h00);
        tick("mask2");
        chk("mask2.pend", pending, 8'h80);
        mask = 8'h00;
        tick("mask3");
        chk("mask3.code", 8'(code), 8'h07);
        tick("mask4");
`endif

        // Reset in the middle of a transfer.
        I = 8'hFF;
        tick("mid0");
        I = 8'h00;
        tick("mid1");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("mid_rst");
        #1;
        rst_n = 1'b1;

        // Random traffic against the reference.
        for (int n = 0; n < 400; n++) begin
            I     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            E     = ($urandom_range(0, 3) != 0);
            ready = ($urandom_range(0, 9) < 7);
`ifdef PENC_MASK_EN
            mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
`endif
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
